// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one registered single-port memory request stage between nreq
// requesters; each response is routed back as a one-hot strobe to the requester that issued it.
module mem_port_rr_arbiter #(
   parameter int nreq  = 4,
   parameter int abits = 16,
   parameter int dbits = 64
) (
   input  logic                    i_clk,
   input  logic                    i_nrst,
   input  logic [nreq-1:0]         i_req_valid,
   output logic [nreq-1:0]         o_req_ready,
   input  logic [nreq-1:0]         i_req_we,
   input  logic [nreq*abits-1:0]   i_req_addr,
   input  logic [nreq*dbits/8-1:0] i_req_wstrb,
   input  logic [nreq*dbits-1:0]   i_req_wdata,
   output logic [nreq-1:0]         o_resp_valid,
   output logic [dbits-1:0]        o_resp_rdata,
   output logic                    o_mem_req,
   output logic                    o_mem_we,
   output logic [abits-1:0]        o_mem_addr,
   output logic [dbits/8-1:0]      o_mem_wstrb,
   output logic [dbits-1:0]        o_mem_wdata,
   input  logic                    i_mem_ready,
   input  logic [dbits-1:0]        i_mem_rdata,
   output logic                    o_busy
);
   localparam int sbits = dbits / 8;
   localparam int pw    = (nreq > 1) ? $clog2(nreq) : 1;

   logic [pw-1:0]    ptr_p1;
   logic [pw-1:0]    tag_p1;
   logic             mem_vld_p1;
   logic             we_p1;
   logic [abits-1:0] addr_p1;
   logic [sbits-1:0] wstrb_p1;
   logic [dbits-1:0] wdata_p1;
   logic [nreq-1:0]  resp_vld_p2;

   logic [pw-1:0]    gnt_idx;
   logic [pw-1:0]    cand;
   logic             gnt_any;
   logic [nreq-1:0]  gnt;
   logic             can_load;
   logic             mem_acc;
   logic             hs;

   function automatic logic [pw-1:0] rr_index(input logic [pw-1:0] base, input int step);
      int s;
      s = (int'(base) + step) % nreq;
      return pw'(s);
   endfunction

   function automatic logic [nreq-1:0] onehot(input logic [pw-1:0] idx);
      logic [nreq-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // p0: arbitration, scanning from the requester after the last one granted
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int i = 1; i <= nreq; i++) begin
         cand = rr_index(ptr_p1, i);
         if (!gnt_any && i_req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt = gnt_any ? onehot(gnt_idx) : '0;
   end

   assign mem_acc     = mem_vld_p1 & i_mem_ready;
   assign can_load    = ~mem_vld_p1 | i_mem_ready;
   assign hs          = gnt_any & can_load & i_nrst;
   assign o_req_ready = gnt & {nreq{can_load & i_nrst}};

   // p1: request stage feeding the memory; p2: response strobe from the tag at accept
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         mem_vld_p1  <= 1'b0;
         we_p1       <= 1'b0;
         addr_p1     <= '0;
         wstrb_p1    <= '0;
         wdata_p1    <= '0;
         tag_p1      <= '0;
         ptr_p1      <= pw'(nreq - 1);
         resp_vld_p2 <= '0;
      end else begin
         if (hs) begin
            mem_vld_p1 <= 1'b1;
            we_p1      <= i_req_we[gnt_idx];
            addr_p1    <= i_req_addr[int'(gnt_idx)*abits +: abits];
            wstrb_p1   <= i_req_wstrb[int'(gnt_idx)*sbits +: sbits];
            wdata_p1   <= i_req_wdata[int'(gnt_idx)*dbits +: dbits];
            tag_p1     <= gnt_idx;
            ptr_p1     <= gnt_idx;
         end else if (mem_acc) begin
            mem_vld_p1 <= 1'b0;
         end
         resp_vld_p2 <= mem_acc ? onehot(tag_p1) : '0;
      end
   end

   assign o_mem_req    = mem_vld_p1;
   assign o_mem_we     = we_p1;
   assign o_mem_addr   = addr_p1;
   assign o_mem_wstrb  = wstrb_p1;
   assign o_mem_wdata  = wdata_p1;
   assign o_resp_valid = resp_vld_p2;
   assign o_resp_rdata = i_mem_rdata;
   assign o_busy       = mem_vld_p1 | (|resp_vld_p2);

endmodule
